spi_host_driver: RTL and testbench

//   SPI host (initiator) for the FPGA side of the board link. Drives the chip's SPI minion pins (cs, sclk, mosi) and samples miso.

---
 rtl/spi_host_driver.sv | 144 ++++++++++++++
 tb/tb_spi_host_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_host_driver.sv
// SPI mode-0 host: one NBITS word per cs-low window, MSB first, full duplex.
// Word to send arrives on recv_*, word captured from miso leaves on send_*.
module spi_host_driver #(
  parameter int unsigned NBITS   = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [NBITS-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             cs,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             busy
);

  localparam int unsigned HW = $clog2(CLK_DIV);
  localparam int unsigned BW = $clog2(NBITS);
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BLAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, HOLD, GAP, RESP} state_t;

  state_t           state, state_n;
  logic [HW-1:0]    hcnt, hcnt_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [NBITS-1:0] tx_sr, tx_sr_n, tx_sh;
  logic [NBITS-1:0] rx_sr, rx_sr_n;
  logic [NBITS-1:0] send_msg_n;
  logic             send_val_n, recv_rdy_n, cs_n, sclk_n, mosi_n, busy_n;
  logic             phase_end;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      send_msg <= '0;
      send_val <= 1'b0;
      recv_rdy <= 1'b1;
      cs       <= 1'b1;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      bit_cnt  <= bit_cnt_n;
      tx_sr    <= tx_sr_n;
      rx_sr    <= rx_sr_n;
      send_msg <= send_msg_n;
      send_val <= send_val_n;
      recv_rdy <= recv_rdy_n;
      cs       <= cs_n;
      sclk     <= sclk_n;
      mosi     <= mosi_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    hcnt_n     = '0;
    bit_cnt_n  = bit_cnt;
    tx_sr_n    = tx_sr;
    rx_sr_n    = rx_sr;
    send_msg_n = send_msg;
    send_val_n = send_val;
    recv_rdy_n = recv_rdy;
    cs_n       = cs;
    sclk_n     = sclk;
    mosi_n     = mosi;
    phase_end  = (hcnt == HLAST);
    tx_sh      = tx_sr << 1;

    // Every timed state lasts exactly CLK_DIV cycles; IDLE and RESP hold the counter at zero.
    if (state != IDLE && state != RESP)
      hcnt_n = phase_end ? '0 : hcnt + 1'b1;

    case (state)
      IDLE: begin
        if (recv_val && recv_rdy) begin
          tx_sr_n    = recv_msg;
          bit_cnt_n  = '0;
          cs_n       = 1'b0;
          mosi_n     = recv_msg[NBITS-1];
          recv_rdy_n = 1'b0;
          state_n    = SETUP;
        end
      end
      SETUP, LOW: begin
        if (phase_end) begin
          sclk_n  = 1'b1;
          rx_sr_n = {rx_sr[NBITS-2:0], miso};
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_n = 1'b0;
          if (bit_cnt == BLAST) begin
            state_n = HOLD;
          end else begin
            mosi_n    = tx_sh[NBITS-1];
            tx_sr_n   = tx_sh;
            bit_cnt_n = bit_cnt + 1'b1;
            state_n   = LOW;
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          cs_n    = 1'b1;
          state_n = GAP;
        end
      end
      GAP: begin
        if (phase_end) begin
          send_msg_n = rx_sr;
          send_val_n = 1'b1;
          state_n    = RESP;
        end
      end
      RESP: begin
        if (send_val && send_rdy) begin
          send_val_n = 1'b0;
          recv_rdy_n = 1'b1;
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_spi_host_driver.sv
// Directed bench for spi_host_driver (NBITS=8, CLK_DIV=4): loopback, tied miso,
// minion model, send backpressure, back-to-back frames and mid-frame reset.
module tb_spi_host_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] recv_msg;
  logic       recv_val;
  logic       recv_rdy;
  logic [7:0] send_msg;
  logic       send_val;
  logic       send_rdy;
  logic       cs, sclk, mosi, miso, busy;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int t_acc = 0;

  int rises = 0;
  int mhi   = 0;
  int hi_run = 0;
  int last_gap = 0;
  int       mode = 0;
  logic [7:0] min_tx = 8'h00;
  logic [7:0] min_rx = 8'h00;
  logic [2:0] min_cnt = 3'd0;

  spi_host_driver #(.NBITS(8), .CLK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!cs && mosi) mhi <= mhi + 1;
    if (cs) hi_run <= hi_run + 1;
    else begin
      if (hi_run != 0) last_gap <= hi_run;
      hi_run <= 0;
    end
  end

  always @(posedge sclk) if (!cs) rises <= rises + 1;

  // Mode-0 minion: restarts at cs fall, captures mosi on sclk rise.
  always @(negedge cs or posedge sclk) begin
    if (sclk) begin
      min_rx  <= {min_rx[6:0], mosi};
      min_cnt <= min_cnt + 3'd1;
    end else begin
      min_cnt <= 3'd0;
    end
  end

  always_comb begin
    case (mode)
      0:       miso = mosi;
      1:       miso = 1'b1;
      default: miso = min_tx[3'd7 - min_cnt];
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] w);
    recv_msg = w;
    recv_val = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_val(output int lat);
    int k = 0;
    while (send_val !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    lat = cyc - t_acc;
  endtask

  initial begin
    int lat, r0, m0, k, sv_seen;
    reset = 1'b1; recv_msg = 8'h00; recv_val = 1'b0; send_rdy = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_cs", cs, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_recv_rdy", recv_rdy, 1);
    check("rst_send_val", send_val, 0);
    check("rst_send_msg", send_msg, 8'h00);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: loopback A5, 72-cycle latency
    mode = 0;
    start(8'hA5);
    check("t1_busy", busy, 1);
    check("t1_rdy_low", recv_rdy, 0);
    wait_val(lat);
    check("t1_latency", lat, 72);
    check("t1_msg", send_msg, 8'hA5);
    @(negedge clk);
    check("t1_val_clr", send_val, 0);
    check("t1_rdy_back", recv_rdy, 1);

    // 2: miso tied high, send 00
    mode = 1;
    r0 = rises; m0 = mhi;
    start(8'h00);
    wait_val(lat);
    check("t2_msg", send_msg, 8'hFF);
    check("t2_rises", rises - r0, 8);
    check("t2_mosi_low", mhi - m0, 0);
    @(negedge clk);

    // 3: minion model returns 3C, host sends C3
    mode = 2; min_tx = 8'h3C;
    start(8'hC3);
    wait_val(lat);
    check("t3_minion_rx", min_rx, 8'hC3);
    check("t3_msg", send_msg, 8'h3C);
    check("t3_latency", lat, 72);
    @(negedge clk);

    // 4: send backpressure, recv_val ignored while busy
    mode = 0; send_rdy = 1'b0;
    start(8'h5A);
    wait_val(lat);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin recv_val = 1'b1; recv_msg = 8'hFF; end
      if (i == 8) recv_val = 1'b0;
      @(negedge clk);
      check("t4_val_held", send_val, 1);
      check("t4_msg_held", send_msg, 8'h5A);
      check("t4_rdy_low", recv_rdy, 0);
    end
    send_rdy = 1'b1;
    @(negedge clk);
    check("t4_val_clr", send_val, 0);
    check("t4_rdy_back", recv_rdy, 1);
    @(negedge clk);
    check("t4_no_accept", cs, 1);
    check("t4_idle", busy, 0);

    // 5: back-to-back with recv_val held high
    recv_msg = 8'h01; recv_val = 1'b1;
    @(negedge clk);
    t_acc = cyc;
    recv_msg = 8'h80;
    wait_val(lat);
    check("t5_msg1", send_msg, 8'h01);
    @(negedge clk);
    @(negedge clk);
    t_acc = cyc;
    recv_val = 1'b0;
    check("t5_second_accept", busy, 1);
    wait_val(lat);
    check("t5_msg2", send_msg, 8'h80);
    check("t5_latency2", lat, 72);
    check("t5_cs_gap", last_gap, 6);
    @(negedge clk);

    // 6: reset after the 3rd sclk rise
    r0 = rises;
    start(8'h5A);
    k = 0;
    while (rises - r0 < 3 && k < 200) begin @(negedge clk); k++; end
    check("t6_third_rise", rises - r0, 3);
    reset = 1'b1;
    #1;
    check("t6_cs", cs, 1);
    check("t6_sclk", sclk, 0);
    check("t6_busy", busy, 0);
    check("t6_rdy", recv_rdy, 1);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    sv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (send_val === 1'b1) sv_seen++;
    end
    check("t6_no_send", sv_seen, 0);
    start(8'h96);
    wait_val(lat);
    check("t6_msg", send_msg, 8'h96);
    check("t6_latency", lat, 72);
    @(negedge clk);
    check("t6_rdy_back", recv_rdy, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
